// File: rtl/mux_seg_scanner.sv
// mux_seg_scanner: multiplexed 8-segment scanner with per-frame snapshot,
// leading-zero blanking, per-digit decimal points and PWM dimming.
module mux_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_LOG2   = 10,
    parameter int PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic [PWM_BITS-1:0]     bright,
    input  logic                    oe,
    output logic [NUM_DIGITS-1:0]   drains,
    output logic [7:0]              segs,
    output logic                    frame
);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [DIV_LOG2-1:0]   pre_cnt;
    logic [DW-1:0]         dig;
    logic [4*NUM_DIGITS-1:0] snap_data;
    logic [NUM_DIGITS-1:0] snap_dp;
    logic                  on;
    logic                  snap;
    logic                  blank;
    logic [3:0]            nib;
    // pre_cnt==0 is the dead cycle separating slots; upper bits form the PWM phase
    always_comb begin
        snap  = pre_cnt == '0 && dig == '0;
        on    = oe && pre_cnt != '0 && pre_cnt[DIV_LOG2-1 -: PWM_BITS] <= bright;
        nib   = snap_data[4*int'(dig) +: 4];
        blank = blank_lz && dig != '0 && (snap_data >> (4*int'(dig))) == '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            dig       <= '0;
            snap_data <= '0;
            snap_dp   <= '0;
            drains    <= '0;
            segs      <= '0;
            frame     <= 1'b0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            if (&pre_cnt)
                dig <= dig == DW'(NUM_DIGITS-1) ? '0 : dig + 1'b1;
            if (snap) begin
                snap_data <= data;
                snap_dp   <= dp;
            end
            frame  <= snap;
            drains <= on ? NUM_DIGITS'(1) << dig : '0;
            segs   <= on ? {snap_dp[dig], blank ? 7'h00 : SEG7[nib]} : '0;
        end
    end
endmodule

// File: tb/tb_mux_seg_scanner.sv
// tb_mux_seg_scanner: directed vector checks of mux_seg_scanner at 4 and 6 digits.
module tb_mux_seg_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] data = '0;
    logic [5:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic        oe = 1'b1;
    logic [3:0]  drains4;
    logic [7:0]  segs4;
    logic        frame4;
    logic [5:0]  drains6;
    logic [7:0]  segs6;
    logic        frame6;
    int pass_cnt = 0;
    int total = 0;
    int cur_c = 0;

    typedef struct {
        bit          n6;
        logic [23:0] data;
        logic [5:0]  dp;
        logic        blz;
        logic [1:0]  bright;
        logic        oe;
        int          c;
        logic [5:0]  drains;
        logic [7:0]  segs;
        logic        frame;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mux_seg_scanner #(.NUM_DIGITS(4), .DIV_LOG2(4), .PWM_BITS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .data(data[15:0]), .dp(dp[3:0]), .blank_lz(blank_lz),
        .bright(bright), .oe(oe), .drains(drains4), .segs(segs4), .frame(frame4)
    );
    mux_seg_scanner #(.NUM_DIGITS(6), .DIV_LOG2(4), .PWM_BITS(2)) u6 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank_lz(blank_lz),
        .bright(bright), .oe(oe), .drains(drains6), .segs(segs6), .frame(frame6)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // leaves the bench at a negedge with reset just released; cur_c counts posedges since release
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur_c = 0;
    endtask

    task automatic step_to(input int c);
        while (cur_c < c) begin
            @(posedge clk);
            @(negedge clk);
            cur_c++;
        end
    endtask

    task automatic add(input bit n6, input logic [23:0] d, input logic [5:0] p, input logic blz,
                       input logic [1:0] br, input logic en, input int c,
                       input logic [5:0] dr, input logic [7:0] sg, input logic fr);
        vec_t v;
        v = '{n6, d, p, blz, br, en, c, dr, sg, fr};
        vecs.push_back(v);
    endtask

    logic [7:0] tear_exp [6] = '{8'h5B, 8'h06, 8'h5E, 8'h39, 8'h7C, 8'h77};

    initial begin
        add(0, 24'h1234, 6'h00, 0, 3, 1,  1, 6'h0, 8'h00, 1);
        add(0, 24'h1234, 6'h00, 0, 3, 1,  2, 6'h1, 8'h66, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 16, 6'h1, 8'h66, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 17, 6'h0, 8'h00, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 18, 6'h2, 8'h4F, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 34, 6'h4, 8'h5B, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 50, 6'h8, 8'h06, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 65, 6'h0, 8'h00, 1);
        add(0, 24'h1234, 6'h00, 0, 3, 1, 66, 6'h1, 8'h66, 0);
        add(0, 24'h0070, 6'h00, 1, 3, 1,  2, 6'h1, 8'h3F, 0);
        add(0, 24'h0070, 6'h00, 1, 3, 1, 18, 6'h2, 8'h07, 0);
        add(0, 24'h0070, 6'h00, 1, 3, 1, 34, 6'h4, 8'h00, 0);
        add(0, 24'h0070, 6'h00, 1, 3, 1, 50, 6'h8, 8'h00, 0);
        add(0, 24'h0070, 6'h00, 0, 3, 1, 50, 6'h8, 8'h3F, 0);
        add(0, 24'h0000, 6'h00, 1, 3, 1,  2, 6'h1, 8'h3F, 0);
        add(0, 24'h0000, 6'h00, 1, 3, 1, 18, 6'h2, 8'h00, 0);
        add(0, 24'h0000, 6'h08, 1, 3, 1, 50, 6'h8, 8'h80, 0);
        add(0, 24'h0000, 6'h01, 1, 3, 1,  2, 6'h1, 8'hBF, 0);
        add(0, 24'h1234, 6'h00, 0, 0, 1,  2, 6'h1, 8'h66, 0);
        add(0, 24'h1234, 6'h00, 0, 0, 1,  4, 6'h1, 8'h66, 0);
        add(0, 24'h1234, 6'h00, 0, 0, 1,  5, 6'h0, 8'h00, 0);
        add(0, 24'h1234, 6'h00, 0, 1, 1,  8, 6'h1, 8'h66, 0);
        add(0, 24'h1234, 6'h00, 0, 1, 1,  9, 6'h0, 8'h00, 0);
        add(0, 24'h1234, 6'h00, 0, 2, 1, 12, 6'h1, 8'h66, 0);
        add(0, 24'h1234, 6'h00, 0, 2, 1, 13, 6'h0, 8'h00, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 0,  1, 6'h0, 8'h00, 1);
        add(0, 24'h1234, 6'h00, 0, 3, 0,  2, 6'h0, 8'h00, 0);
        add(0, 24'h1234, 6'h00, 0, 3, 0, 65, 6'h0, 8'h00, 1);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1,  2, 6'h01, 8'hB9, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 18, 6'h02, 8'h5E, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 34, 6'h04, 8'hF9, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 50, 6'h08, 8'h71, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 66, 6'h10, 8'h3F, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 82, 6'h20, 8'h3F, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 65, 6'h00, 8'h00, 0);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 97, 6'h00, 8'h00, 1);
        add(1, 24'h00FEDC, 6'h05, 0, 3, 1, 98, 6'h01, 8'hB9, 0);
        add(1, 24'h00FEDC, 6'h05, 1, 3, 1, 50, 6'h08, 8'h71, 0);
        add(1, 24'h00FEDC, 6'h05, 1, 3, 1, 66, 6'h10, 8'h00, 0);
        add(1, 24'h00FEDC, 6'h05, 1, 3, 1, 82, 6'h20, 8'h00, 0);

        // outputs forced off by reset while a digit is lit
        data = 24'h1234; dp = '0; blank_lz = 0; bright = 3; oe = 1;
        do_reset();
        step_to(20);
        check("lit_before_reset", int'(drains4), 2);
        do_reset();
        check("rst_drains4", int'(drains4), 0);
        check("rst_segs4", int'(segs4), 0);
        check("rst_frame4", int'(frame4), 0);
        check("rst_drains6", int'(drains6), 0);
        check("rst_segs6", int'(segs6), 0);
        check("rst_frame6", int'(frame6), 0);

        foreach (vecs[i]) begin
            data = vecs[i].data; dp = vecs[i].dp; blank_lz = vecs[i].blz;
            bright = vecs[i].bright; oe = vecs[i].oe;
            do_reset();
            step_to(vecs[i].c);
            check($sformatf("v%0d_c%0d_drains", i, vecs[i].c),
                  vecs[i].n6 ? int'(drains6) : int'(drains4), int'(vecs[i].drains));
            check($sformatf("v%0d_c%0d_segs", i, vecs[i].c),
                  vecs[i].n6 ? int'(segs6) : int'(segs4), int'(vecs[i].segs));
            check($sformatf("v%0d_c%0d_frame", i, vecs[i].c),
                  vecs[i].n6 ? int'(frame6) : int'(frame4), int'(vecs[i].frame));
        end

        // data changes mid-frame must not tear the current frame
        data = 24'h1234; dp = '0; blank_lz = 0; bright = 3; oe = 1;
        do_reset();
        step_to(18);
        check("tear_dig1", int'(segs4), 8'h4F);
        data = 24'hABCD;
        for (int k = 0; k < 6; k++) begin
            step_to(34 + 16*k);
            check($sformatf("tear_c%0d", cur_c), int'(segs4), int'(tear_exp[k]));
        end

        // one-cycle reset mid-frame restarts the scan with a fresh snapshot
        data = 24'h1234;
        do_reset();
        step_to(40);
        check("mid_dig2", int'(drains4), 4);
        rst_n = 1'b0;
        data = 24'h0005;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_drains", int'(drains4), 0);
        check("mid_rst_segs", int'(segs4), 0);
        check("mid_rst_frame", int'(frame4), 0);
        rst_n = 1'b1;
        cur_c = 0;
        step_to(1);
        check("mid_frame", int'(frame4), 1);
        step_to(2);
        check("mid_drains", int'(drains4), 1);
        check("mid_segs", int'(segs4), 8'h6D);

        // oe sampled live; scan keeps running while dark
        data = 24'h1234;
        do_reset();
        step_to(5);
        check("oe_on", int'(drains4), 1);
        oe = 1'b0;
        step_to(6);
        check("oe_off_drains", int'(drains4), 0);
        check("oe_off_segs", int'(segs4), 0);
        step_to(65);
        check("oe_off_frame", int'(frame4), 1);
        oe = 1'b1;
        step_to(66);
        check("oe_back_drains", int'(drains4), 1);
        check("oe_back_segs", int'(segs4), 8'h66);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
